micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer.sv | 159 +++++++++++++++
 tb/tb_micro_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogrammed control sequencer with a writable program store.
// Each microinstruction is {seq_op[1:0], target[AW-1:0], control_word[CW-1:0]}.
// While running, the control word at upc is issued combinationally and the
// sequencing op picks the next upc (continue, branch on mayor, branch on
// bandera, halt).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset (clears FSM, upc and program store)
//   start      begin execution at address 0 (honoured in IDLE only)
//   step       (SEQ_STEP_EN builds only) single-step enable while running
//   mayor      ALU comparison flag for the word currently issued
//   bandera    ALU parity flag for the word currently issued
//   prog_we    program store write strobe (honoured in IDLE/DONE only)
//   prog_addr  program store write address
//   prog_data  program store write data
//   o_signal   control word to the datapath (zero when not issuing)
//   busy       high while running
//   done       one-cycle pulse after the HALT word
//   upc        current micro-program counter
//
// Configuration macro: SEQ_STEP_EN adds the step input; with it undefined the
// sequencer advances every running cycle.
module micro_sequencer #(
  parameter int unsigned CW = 16,
  parameter int unsigned AW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef SEQ_STEP_EN
  input  logic                 step,
`endif
  input  logic                 mayor,
  input  logic                 bandera,
  input  logic                 prog_we,
  input  logic [AW-1:0]        prog_addr,
  input  logic [CW+AW+1:0]     prog_data,
  output logic [CW-1:0]        o_signal,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        upc
);

  localparam int unsigned IW    = CW + AW + 2;
  localparam int unsigned DEPTH = 2 ** AW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_CONT       = 2'b00;
  localparam logic [1:0] OP_BR_MAYOR   = 2'b01;
  localparam logic [1:0] OP_BR_BANDERA = 2'b10;
  localparam logic [1:0] OP_HALT       = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] upc_q, upc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [IW-1:0] store_q [DEPTH];
  logic [IW-1:0] store_d [DEPTH];

  logic [IW-1:0] cur_word;
  logic [1:0]    cur_op;
  logic [AW-1:0] cur_target;
  logic [AW-1:0] upc_inc;
  logic          adv;

  // Advance qualifier: single-step gate when enabled, otherwise always advance.
`ifdef SEQ_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // Decode of the word currently addressed by upc.
  assign cur_word   = store_q[upc_q];
  assign cur_op     = cur_word[IW-1:IW-2];
  assign cur_target = cur_word[CW+AW-1:CW];
  assign upc_inc    = upc_q + AW'(1);

  // Program store next state: writes are locked out while running.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      store_d[i] = store_q[i];
    end
    if (prog_we && (state_q != ST_RUN)) begin
      store_d[prog_addr] = prog_data;
    end
  end

  // Next-state and next-upc logic.
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          upc_d   = '0;
        end
      end
      ST_RUN: begin
        if (adv) begin
          case (cur_op)
            OP_CONT:       upc_d = upc_inc;
            OP_BR_MAYOR:   upc_d = mayor   ? cur_target : upc_inc;
            OP_BR_BANDERA: upc_d = bandera ? cur_target : upc_inc;
            OP_HALT:       state_d = ST_DONE;
            default:       upc_d = upc_inc;
          endcase
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, status and program store registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        store_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        store_q[i] <= store_d[i];
      end
    end
  end

  // Zero-latency issue: the addressed control word goes out in the same cycle.
  always_comb begin
    o_signal = '0;
    if ((state_q == ST_RUN) && adv) begin
      o_signal = cur_word[CW-1:0];
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign upc  = upc_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: per-cycle vector tables with a scoreboard of
// expected outputs, plus hand-written reset sequences.
module tb_micro_sequencer;

  localparam int unsigned CW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned IW = CW + AW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          step;
  logic          mayor;
  logic          bandera;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [CW-1:0] o_signal;
  logic          busy;
  logic          done;
  logic [AW-1:0] upc;

  always #5 clk = ~clk;

  micro_sequencer #(.CW(CW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef SEQ_STEP_EN
    .step      (step),
`endif
    .mayor     (mayor),
    .bandera   (bandera),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .o_signal  (o_signal),
    .busy      (busy),
    .done      (done),
    .upc       (upc)
  );

  typedef struct {
    logic          start;
    logic          we;
    logic [AW-1:0] waddr;
    logic [IW-1:0] wdata;
    logic          mayor;
    logic          bandera;
    logic          step;
    logic [CW-1:0] sig;
    logic [AW-1:0] upc;
    logic          busy;
    logic          done;
  } vec_t;

  typedef struct {
    logic [CW-1:0] sig;
    logic [AW-1:0] upc;
    logic          busy;
    logic          done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [IW-1:0] mk(input logic [1:0] op, input logic [AW-1:0] tgt,
                                       input logic [CW-1:0] cw);
    return {op, tgt, cw};
  endfunction

  function automatic vec_t mkv(input logic st, input logic we, input logic [AW-1:0] wa,
                               input logic [IW-1:0] wd, input logic my, input logic bd,
                               input logic sp, input logic [CW-1:0] sig,
                               input logic [AW-1:0] u, input logic b, input logic d);
    vec_t v;
    v.start = st; v.we = we; v.waddr = wa; v.wdata = wd;
    v.mayor = my; v.bandera = bd; v.step = sp;
    v.sig = sig; v.upc = u; v.busy = b; v.done = d;
    return v;
  endfunction

  // Issue-cycle record with no write and step=1.
  function automatic vec_t rv(input logic st, input logic my, input logic bd,
                              input logic [CW-1:0] sig, input logic [AW-1:0] u,
                              input logic b, input logic d);
    return mkv(st, 1'b0, '0, '0, my, bd, 1'b1, sig, u, b, d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_outputs(input string name, input exp_t e);
    check({name, ".o_signal"}, 32'(o_signal), 32'(e.sig));
    check({name, ".upc"},      32'(upc),      32'(e.upc));
    check({name, ".busy"},     32'(busy),     32'(e.busy));
    check({name, ".done"},     32'(done),     32'(e.done));
  endtask

  task automatic clear_inputs();
    start = 1'b0; step = 1'b1; mayor = 1'b0; bandera = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Drive each record for one cycle; outputs of that cycle are checked before the edge.
  task automatic run_vecs(input string tag);
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start = vecs[i].start; prog_we = vecs[i].we; prog_addr = vecs[i].waddr;
      prog_data = vecs[i].wdata; mayor = vecs[i].mayor; bandera = vecs[i].bandera;
      step = vecs[i].step;
      sb.push_back('{vecs[i].sig, vecs[i].upc, vecs[i].busy, vecs[i].done});
      #1;
      if (sb.size() == 0) begin
        check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_outputs($sformatf("%s[%0d]", tag, i), e);
      end
    end
    vecs.delete();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic pulse_reset(input string tag);
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    #1;
    e = '{'0, '0, 1'b0, 1'b0};
    check_outputs(tag, e);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    clear_inputs();
    #1;
    e = '{'0, '0, 1'b0, 1'b0};
    check_outputs("reset", e);
    @(negedge clk);
    rst = 1'b0;

    // Straight-line program; word 0 rewritten in the start cycle; start ignored in DONE.
    write_word(4'd0, mk(2'b00, '0, 16'hDEAD));
    write_word(4'd1, mk(2'b00, '0, 16'h4005));
    write_word(4'd2, mk(2'b11, '0, 16'h0007));
    vecs.push_back(mkv(1'b1, 1'b1, 4'd0, mk(2'b00, '0, 16'h2003), 1'b0, 1'b0, 1'b1,
                       16'h0000, 4'd0, 1'b0, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b0, 16'h2003, 4'd0, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b0, 16'h4005, 4'd1, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b0, 16'h0007, 4'd2, 1'b1, 1'b0));
    vecs.push_back(rv(1'b1, 1'b0, 1'b0, 16'h0000, 4'd2, 1'b0, 1'b1));
    vecs.push_back(rv(1'b0, 1'b0, 1'b0, 16'h0000, 4'd2, 1'b0, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b0, 16'h0000, 4'd2, 1'b0, 1'b0));
    run_vecs("linear");

    // BR_MAYOR taken, then not taken.
    write_word(4'd0, mk(2'b00, '0, 16'h0001));
    write_word(4'd1, mk(2'b01, 4'd5, 16'h0002));
    write_word(4'd2, mk(2'b11, '0, 16'h0003));
    write_word(4'd5, mk(2'b11, '0, 16'h0005));
    vecs.push_back(rv(1'b1, 1'b0, 1'b0, 16'h0000, 4'd2, 1'b0, 1'b0));
    vecs.push_back(rv(1'b0, 1'b1, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b1, 1'b0, 16'h0002, 4'd1, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b0, 16'h0005, 4'd5, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b0, 16'h0000, 4'd5, 1'b0, 1'b1));
    vecs.push_back(rv(1'b0, 1'b0, 1'b0, 16'h0000, 4'd5, 1'b0, 1'b0));
    vecs.push_back(rv(1'b1, 1'b0, 1'b0, 16'h0000, 4'd5, 1'b0, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b1, 16'h0002, 4'd1, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b0, 16'h0003, 4'd2, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b0, 16'h0000, 4'd2, 1'b0, 1'b1));
    run_vecs("br_mayor");

    // BR_BANDERA loop 0..3 -> 0, then reset mid-loop.
    write_word(4'd0, mk(2'b00, '0, 16'h0011));
    write_word(4'd1, mk(2'b00, '0, 16'h0012));
    write_word(4'd2, mk(2'b00, '0, 16'h0013));
    write_word(4'd3, mk(2'b10, 4'd0, 16'h0014));
    vecs.push_back(rv(1'b1, 1'b0, 1'b1, 16'h0000, 4'd2, 1'b0, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b1, 16'h0011, 4'd0, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b1, 16'h0012, 4'd1, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b1, 16'h0013, 4'd2, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b1, 16'h0014, 4'd3, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b1, 16'h0011, 4'd0, 1'b1, 1'b0));
    vecs.push_back(rv(1'b0, 1'b0, 1'b1, 16'h0012, 4'd1, 1'b1, 1'b0));
    run_vecs("br_bandera");
    // The loop is still running here (upc=3 after the clearing edge); reset must cut it.
    pulse_reset("rst_mid_run");

    // Cleared store: every address issues zero and sequences as CONT.
    vecs.push_back(rv(1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0));
    for (int i = 0; i < 18; i++) begin
      vecs.push_back(rv(1'b0, 1'b0, 1'b0, 16'h0000, AW'(i % 16), 1'b1, 1'b0));
    end
    run_vecs("cleared_store");
    pulse_reset("rst_after_cleared");

    // Full 16-word CONT program wraps; write during RUN is ignored.
    for (int i = 0; i < 16; i++) begin
      write_word(AW'(i), mk(2'b00, '0, CW'(16'h0100 + i)));
    end
    vecs.push_back(rv(1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0));
    for (int i = 0; i < 19; i++) begin
      vecs.push_back(mkv(1'b0, (i == 1), 4'd2, mk(2'b00, '0, 16'hBEEF), 1'b0, 1'b0, 1'b1,
                         CW'(16'h0100 + (i % 16)), AW'(i % 16), 1'b1, 1'b0));
    end
    run_vecs("wrap");
    pulse_reset("rst_after_wrap");

`ifdef SEQ_STEP_EN
    // Single-step: issue only on step=1, HALT completes on the second step.
    write_word(4'd0, mk(2'b00, '0, 16'h000A));
    write_word(4'd1, mk(2'b11, '0, 16'h000B));
    vecs.push_back(mkv(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mkv(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 16'h000A, 4'd0, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd1, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 16'h000B, 4'd1, 1'b1, 1'b0));
    vecs.push_back(mkv(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd1, 1'b0, 1'b1));
    vecs.push_back(mkv(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd1, 1'b0, 1'b0));
    run_vecs("step");
`endif

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
